// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch -- MM:SS stopwatch driven by the divided 1 Hz square wave.
//
// The slow square wave from the clock divider is resynchronised into the
// clk_in domain and edge-detected. Each rising edge seen while running
// advances a four-digit BCD count (00:00 .. 59:59) that wraps to 00:00.
// A start/stop/clear state machine (IDLE, RUN, PAUSE) gates the counting.
//
// Optional feature: define STOPWATCH_LAP_EN to add lap capture
// (ports lap, lap_value, lap_valid).
//
// Ports:
//   clk_in     system clock (same clock as the divider stage)
//   rst        synchronous active-high reset
//   sec_clk    divided square wave, treated as asynchronous data
//   start      level, requests RUN
//   stop       level, requests PAUSE
//   clear      level, forces IDLE and zeroes the count
//   sec_lo     BCD seconds units (0-9)
//   sec_hi     BCD seconds tens  (0-5)
//   min_lo     BCD minutes units (0-9)
//   min_hi     BCD minutes tens  (0-5)
//   running    high while the state is RUN
//   tick       one-cycle pulse per counted second
//   wrap       one-cycle pulse on the 59:59 -> 00:00 rollover
//   lap        (lap build) capture request, honoured in RUN or PAUSE
//   lap_value  (lap build) captured {min_hi,min_lo,sec_hi,sec_lo}
//   lap_valid  (lap build) one-cycle pulse after a capture
module bcd_stopwatch #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic        sec_clk,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
`ifdef STOPWATCH_LAP_EN
   input  logic        lap,
   output logic [15:0] lap_value,
   output logic        lap_valid,
`endif
   output logic [3:0]  sec_lo,
   output logic [3:0]  sec_hi,
   output logic [3:0]  min_lo,
   output logic [3:0]  min_hi,
   output logic        running,
   output logic        tick,
   output logic        wrap
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t state, next_state;

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;
   logic                   sec_edge;
   logic                   count_en;
   logic                   at_max;

   // Synchroniser chain and edge detector. prev resets to 0 so a sec_clk
   // that is already high at reset release produces one (discarded) edge.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], sec_clk};
         prev <= sync[SYNC_STAGES-1];
      end
   end

   assign sec_edge = sync[SYNC_STAGES-1] & ~prev;

   // Only the registered state gates counting, so the edge in the cycle
   // that start leaves IDLE/PAUSE is dropped while the edge in the cycle
   // that stop is asserted in RUN still counts.
   assign count_en = (state == RUN) && sec_edge && !clear;
   assign at_max   = (min_hi == 4'd5) && (min_lo == 4'd9) &&
                     (sec_hi == 4'd5) && (sec_lo == 4'd9);

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state   <= IDLE;
         running <= 1'b0;
      end else begin
         state   <= next_state;
         running <= (next_state == RUN);
      end
   end

   // Priority clear > stop > start: stop outside RUN is a no-op but still
   // masks a simultaneous start.
   always_comb begin
      next_state = state;
      if (clear) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (!stop && start) next_state = RUN;
            RUN:     if (stop) next_state = PAUSE;
            PAUSE:   if (!stop && start) next_state = RUN;
            default: next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         sec_lo <= 4'd0;
         sec_hi <= 4'd0;
         min_lo <= 4'd0;
         min_hi <= 4'd0;
         tick   <= 1'b0;
         wrap   <= 1'b0;
      end else begin
         tick <= count_en;
         wrap <= count_en && at_max;
         if (clear) begin
            sec_lo <= 4'd0;
            sec_hi <= 4'd0;
            min_lo <= 4'd0;
            min_hi <= 4'd0;
         end else if (count_en) begin
            // BCD ripple: each digit only moves when all lower digits wrap.
            if (sec_lo != 4'd9) begin
               sec_lo <= sec_lo + 4'd1;
            end else begin
               sec_lo <= 4'd0;
               if (sec_hi != 4'd5) begin
                  sec_hi <= sec_hi + 4'd1;
               end else begin
                  sec_hi <= 4'd0;
                  if (min_lo != 4'd9) begin
                     min_lo <= min_lo + 4'd1;
                  end else begin
                     min_lo <= 4'd0;
                     if (min_hi != 4'd5) min_hi <= min_hi + 4'd1;
                     else                min_hi <= 4'd0;
                  end
               end
            end
         end
      end
   end

`ifdef STOPWATCH_LAP_EN
   // Capture uses the pre-update digit registers, so a lap coinciding with
   // a counted edge records the value before the increment.
   always_ff @(posedge clk_in) begin
      if (rst || clear) begin
         lap_value <= 16'h0000;
         lap_valid <= 1'b0;
      end else begin
         lap_valid <= 1'b0;
         if (lap && (state == RUN || state == PAUSE)) begin
            lap_value <= {min_hi, min_lo, sec_hi, sec_lo};
            lap_valid <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed testbench for bcd_stopwatch: reset, counting latency, rollover,
// pause/resume, clear-vs-edge priority and (when built with
// STOPWATCH_LAP_EN) lap capture.
module tb_bcd_stopwatch;

   localparam int SYNC_STAGES = 2;

   logic       clk_in = 1'b0;
   logic       rst = 1'b1;
   logic       sec_clk = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] sec_lo, sec_hi, min_lo, min_hi;
   logic       running, tick, wrap;
`ifdef STOPWATCH_LAP_EN
   logic        lap = 1'b0;
   logic [15:0] lap_value;
   logic        lap_valid;
`endif

   int n_vec = 0;
   int n_err = 0;

   bcd_stopwatch #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .clk_in  (clk_in),
      .rst     (rst),
      .sec_clk (sec_clk),
      .start   (start),
      .stop    (stop),
      .clear   (clear),
`ifdef STOPWATCH_LAP_EN
      .lap       (lap),
      .lap_value (lap_value),
      .lap_valid (lap_valid),
`endif
      .sec_lo  (sec_lo),
      .sec_hi  (sec_hi),
      .min_lo  (min_lo),
      .min_hi  (min_hi),
      .running (running),
      .tick    (tick),
      .wrap    (wrap)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [15:0] digits();
      return {min_hi, min_lo, sec_hi, sec_lo};
   endfunction

   // Advance past the next rising edge; inputs change and outputs are read here.
   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; sec_clk = 1'b0;
      repeat (SYNC_STAGES + 2) cyc();
      rst = 1'b0;
      cyc();
   endtask

   task automatic pulse_start();
      start = 1'b1; cyc(); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; cyc(); stop = 1'b0;
   endtask

   // One 20-cycle second (10 high, 10 low). Records ticks, wraps, ticks
   // not landing SYNC_STAGES edges after the sampling edge, and wraps
   // without a tick.
   task automatic one_sec(output int ticks, output int wraps,
                          output int late, output int lone_wrap);
      ticks = 0; wraps = 0; late = 0; lone_wrap = 0;
      sec_clk = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (tick) begin
            ticks++;
            if (i != SYNC_STAGES) late++;
         end
         if (wrap) begin
            wraps++;
            if (!tick) lone_wrap++;
         end
         if (i == 9) sec_clk = 1'b0;
      end
   endtask

   // Short 4-cycle second used to reach far-off counts quickly.
   task automatic fast_secs(input int n);
      for (int k = 0; k < n; k++) begin
         sec_clk = 1'b1; cyc(); cyc();
         sec_clk = 1'b0; cyc(); cyc();
      end
      repeat (SYNC_STAGES + 2) cyc();
   endtask

   task automatic test_reset();
      int ticks;
      rst = 1'b1; sec_clk = 1'b1;
      repeat (3) cyc();
      n_vec++;
      if ({digits(), running, tick, wrap} !== 19'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got digits=%h run=%b tick=%b wrap=%b, want all 0",
                  digits(), running, tick, wrap);
      end
      rst = 1'b0;
      ticks = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (tick) ticks++;
         if (i == 4) sec_clk = 1'b0;
      end
      n_vec++;
      if (ticks !== 0) begin
         n_err++;
         $display("FAIL reset_release_edge: got %0d ticks, want 0", ticks);
      end
      n_vec++;
      if (digits() !== 16'h0000 || running !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release_digits: got %h run=%b, want 0000 run=0", digits(), running);
      end
   endtask

   task automatic test_count();
      int t, w, l, lw, tt, late_tot;
      do_reset();
      pulse_start();
      n_vec++;
      if (running !== 1'b1) begin
         n_err++;
         $display("FAIL count_running: got %b, want 1", running);
      end
      tt = 0; late_tot = 0;
      for (int s = 0; s < 12; s++) begin
         one_sec(t, w, l, lw);
         tt += t; late_tot += l;
      end
      n_vec++;
      if (tt !== 12) begin
         n_err++;
         $display("FAIL count_ticks: got %0d, want 12", tt);
      end
      n_vec++;
      if (late_tot !== 0) begin
         n_err++;
         $display("FAIL count_latency: got %0d misplaced ticks, want 0", late_tot);
      end
      n_vec++;
      if (digits() !== 16'h0012) begin
         n_err++;
         $display("FAIL count_digits: got %h, want 0012", digits());
      end
   endtask

   task automatic test_wrap();
      int t, w, l, lw;
      do_reset();
      pulse_start();
      fast_secs(3598);
      n_vec++;
      if (digits() !== 16'h5958) begin
         n_err++;
         $display("FAIL wrap_preset: got %h, want 5958", digits());
      end
      one_sec(t, w, l, lw);
      n_vec++;
      if (digits() !== 16'h5959 || t !== 1 || w !== 0) begin
         n_err++;
         $display("FAIL wrap_5959: got %h ticks=%0d wraps=%0d, want 5959 1 0", digits(), t, w);
      end
      one_sec(t, w, l, lw);
      n_vec++;
      if (digits() !== 16'h0000 || t !== 1 || w !== 1 || lw !== 0) begin
         n_err++;
         $display("FAIL wrap_rollover: got %h ticks=%0d wraps=%0d lone=%0d, want 0000 1 1 0",
                  digits(), t, w, lw);
      end
   endtask

   task automatic test_pause();
      int t, w, l, lw, tt;
      do_reset();
      pulse_start();
      fast_secs(5);
      n_vec++;
      if (digits() !== 16'h0005) begin
         n_err++;
         $display("FAIL pause_preset: got %h, want 0005", digits());
      end
      pulse_stop();
      n_vec++;
      if (running !== 1'b0) begin
         n_err++;
         $display("FAIL pause_running: got %b, want 0", running);
      end
      tt = 0;
      for (int s = 0; s < 3; s++) begin
         one_sec(t, w, l, lw);
         tt += t;
      end
      n_vec++;
      if (digits() !== 16'h0005 || tt !== 0) begin
         n_err++;
         $display("FAIL pause_hold: got %h ticks=%0d, want 0005 0", digits(), tt);
      end
      pulse_start();
      n_vec++;
      if (running !== 1'b1) begin
         n_err++;
         $display("FAIL resume_running: got %b, want 1", running);
      end
      one_sec(t, w, l, lw);
      n_vec++;
      if (digits() !== 16'h0006 || t !== 1) begin
         n_err++;
         $display("FAIL resume_count: got %h ticks=%0d, want 0006 1", digits(), t);
      end
      // Reset mid-count overrides a simultaneous start and a live edge.
      rst = 1'b1; start = 1'b1; sec_clk = 1'b1;
      cyc();
      rst = 1'b0; start = 1'b0; sec_clk = 1'b0;
      n_vec++;
      if ({digits(), running, tick, wrap} !== 19'h0) begin
         n_err++;
         $display("FAIL midcount_reset: got digits=%h run=%b tick=%b wrap=%b, want all 0",
                  digits(), running, tick, wrap);
      end
   endtask

   task automatic test_clear_edge();
      int ticks;
      do_reset();
      pulse_start();
      fast_secs(207);
      n_vec++;
      if (digits() !== 16'h0327) begin
         n_err++;
         $display("FAIL clear_preset: got %h, want 0327", digits());
      end
      // After SYNC_STAGES edges the detected edge is live; clear lands on it.
      sec_clk = 1'b1;
      repeat (SYNC_STAGES) cyc();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      n_vec++;
      if (digits() !== 16'h0000 || tick !== 1'b0 || running !== 1'b0) begin
         n_err++;
         $display("FAIL clear_vs_edge: got %h tick=%b run=%b, want 0000 0 0",
                  digits(), tick, running);
      end
      sec_clk = 1'b0;
      repeat (4) cyc();
      start = 1'b1; stop = 1'b1;
      cyc();
      start = 1'b0; stop = 1'b0;
      n_vec++;
      if (running !== 1'b0) begin
         n_err++;
         $display("FAIL idle_start_stop: got running=%b, want 0", running);
      end
      ticks = 0;
      sec_clk = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (tick) ticks++;
         if (i == 4) sec_clk = 1'b0;
      end
      n_vec++;
      if (ticks !== 0 || digits() !== 16'h0000) begin
         n_err++;
         $display("FAIL idle_discard: got ticks=%0d digits=%h, want 0 0000", ticks, digits());
      end
   endtask

`ifdef STOPWATCH_LAP_EN
   task automatic test_lap();
      do_reset();
      pulse_start();
      fast_secs(69);
      sec_clk = 1'b1;
      repeat (SYNC_STAGES) cyc();
      lap = 1'b1;
      cyc();
      lap = 1'b0;
      n_vec++;
      if (lap_valid !== 1'b1 || lap_value !== 16'h0109 || digits() !== 16'h0110 || tick !== 1'b1) begin
         n_err++;
         $display("FAIL lap_capture: got valid=%b value=%h digits=%h tick=%b, want 1 0109 0110 1",
                  lap_valid, lap_value, digits(), tick);
      end
      cyc();
      n_vec++;
      if (lap_valid !== 1'b0) begin
         n_err++;
         $display("FAIL lap_pulse: got valid=%b, want 0", lap_valid);
      end
      sec_clk = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_count();
      test_wrap();
      test_pause();
      test_clear_edge();
`ifdef STOPWATCH_LAP_EN
      test_lap();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
